// File: rtl/mps_intl_handler.sv
// Interlock manager: per-channel sync/debounce, masked fault latch, first-fault
// capture and an IDLE/RUN/FAULT machine driving a registered PWM enable.
module mps_intl_handler #(
   parameter int                    C_INTL_NUM  = 16,
   parameter logic [C_INTL_NUM-1:0] C_INTL_POL  = {C_INTL_NUM{1'b1}},
   parameter int                    C_DB_WIDTH  = 16,
   parameter int                    C_IDX_WIDTH = $clog2(C_INTL_NUM)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [C_INTL_NUM-1:0]  i_intl_raw,
   input  logic [C_INTL_NUM-1:0]  i_intl_mask,
   input  logic [C_DB_WIDTH-1:0]  i_db_cnt,
   input  logic                   i_pwm_en_req,
   input  logic                   i_clear,
   output logic                   o_pwm_en,
   output logic [C_INTL_NUM-1:0]  o_intl_live,
   output logic [C_INTL_NUM-1:0]  o_intl_state,
   output logic                   o_intl_any,
   output logic [C_IDX_WIDTH-1:0] o_first_idx,
   output logic                   o_first_valid,
   output logic                   o_clear_rej,
   output logic [15:0]            o_trip_cnt,
   output logic [1:0]             o_fsm_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_FAULT = 2'b10
   } fsm_t;

   fsm_t                   fsm_q;
   logic                   pwm_q;
   logic [15:0]            trip_q;
   logic                   rej_q;

   logic [C_INTL_NUM-1:0]  sync1_q, sync2_q;
   logic [C_INTL_NUM-1:0]  fault_raw_q, fault_raw_d;
   logic [C_INTL_NUM-1:0]  live_q, live_d;
   logic [C_DB_WIDTH-1:0]  db_cnt_q [C_INTL_NUM];
   logic [C_DB_WIDTH-1:0]  db_cnt_d [C_INTL_NUM];
   logic [C_DB_WIDTH:0]    db_thr;
   logic [C_DB_WIDTH:0]    cnt_inc;

   logic [C_INTL_NUM-1:0]  state_q, state_d;
   logic                   any_q, any_d;
   logic [C_IDX_WIDTH-1:0] first_idx_q, first_idx_d;
   logic                   first_vld_q, first_vld_d;
   logic [C_IDX_WIDTH-1:0] first_hit;

   logic                   req_q, req_d_q;
   logic                   req_v1_q, req_v2_q;
   logic                   req_rise;

   logic [C_INTL_NUM-1:0]  live_m;
   logic                   new_fault;
   logic                   state_nz;
   logic                   clr_ok;

   // Synchronisers idle at the inactive pin level so reset never looks like a fault
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sync1_q     <= ~C_INTL_POL;
         sync2_q     <= ~C_INTL_POL;
         fault_raw_q <= '0;
      end else begin
         sync1_q     <= i_intl_raw;
         sync2_q     <= sync1_q;
         fault_raw_q <= fault_raw_d;
      end
   end

   assign fault_raw_d = sync2_q ~^ C_INTL_POL;

   // A zero debounce setting behaves as a single-cycle qualification
   assign db_thr = (i_db_cnt == '0) ? {{C_DB_WIDTH{1'b0}}, 1'b1} : {1'b0, i_db_cnt};

   always_comb begin
      live_d  = live_q;
      cnt_inc = '0;
      for (int k = 0; k < C_INTL_NUM; k++) begin
         db_cnt_d[k] = '0;
         cnt_inc     = {1'b0, db_cnt_q[k]} + {{C_DB_WIDTH{1'b0}}, 1'b1};
         if (fault_raw_q[k] != live_q[k]) begin
            if (cnt_inc >= db_thr) begin
               live_d[k] = ~live_q[k];
            end else if (&db_cnt_q[k]) begin
               db_cnt_d[k] = db_cnt_q[k];
            end else begin
               db_cnt_d[k] = cnt_inc[C_DB_WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         live_q <= '0;
         for (int k = 0; k < C_INTL_NUM; k++) db_cnt_q[k] <= '0;
      end else begin
         live_q <= live_d;
         for (int k = 0; k < C_INTL_NUM; k++) db_cnt_q[k] <= db_cnt_d[k];
      end
   end

   assign live_m    = live_q & i_intl_mask;
   assign new_fault = |(live_m & ~state_q);
   assign state_nz  = |state_q;
   assign clr_ok    = (fsm_q == ST_FAULT) && i_clear && (live_m == '0) && !new_fault;

   always_comb begin
      first_hit = '0;
      for (int k = C_INTL_NUM - 1; k >= 0; k--) begin
         if (live_m[k]) first_hit = C_IDX_WIDTH'(k);
      end
   end

   always_comb begin
      state_d     = state_q | live_m;
      first_idx_d = first_idx_q;
      first_vld_d = first_vld_q;
      if (clr_ok) begin
         state_d     = '0;
         first_idx_d = '0;
         first_vld_d = 1'b0;
      end else if (!state_nz && (live_m != '0)) begin
         first_idx_d = first_hit;
         first_vld_d = 1'b1;
      end
      any_d = |state_d;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= '0;
         any_q       <= 1'b0;
         first_idx_q <= '0;
         first_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         any_q       <= any_d;
         first_idx_q <= first_idx_d;
         first_vld_q <= first_vld_d;
      end
   end

   // Edge detect only once req_d holds a real post-reset sample, so a request
   // held high across reset release is not mistaken for a fresh arm
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         req_q    <= 1'b0;
         req_d_q  <= 1'b0;
         req_v1_q <= 1'b0;
         req_v2_q <= 1'b0;
      end else begin
         req_q    <= i_pwm_en_req;
         req_d_q  <= req_q;
         req_v1_q <= 1'b1;
         req_v2_q <= req_v1_q;
      end
   end

   assign req_rise = req_q && !req_d_q && req_v2_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         fsm_q  <= ST_IDLE;
         pwm_q  <= 1'b0;
         trip_q <= '0;
         rej_q  <= 1'b0;
      end else begin
         pwm_q <= 1'b0;
         rej_q <= 1'b0;
         case (fsm_q)
            ST_IDLE: begin
               if (state_nz || new_fault) begin
                  fsm_q <= ST_FAULT;
               end else if (req_rise) begin
                  fsm_q <= ST_RUN;
                  pwm_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (state_nz || new_fault) begin
                  fsm_q <= ST_FAULT;
                  if (trip_q != 16'hFFFF) trip_q <= trip_q + 16'd1;
               end else if (!req_q) begin
                  fsm_q <= ST_IDLE;
               end else begin
                  pwm_q <= 1'b1;
               end
            end
            ST_FAULT: begin
               if (i_clear) begin
                  if (clr_ok) fsm_q <= ST_IDLE;
                  else        rej_q <= 1'b1;
               end
            end
            default: fsm_q <= ST_IDLE;
         endcase
      end
   end

   assign o_pwm_en      = pwm_q;
   assign o_intl_live   = live_q;
   assign o_intl_state  = state_q;
   assign o_intl_any    = any_q;
   assign o_first_idx   = first_idx_q;
   assign o_first_valid = first_vld_q;
   assign o_clear_rej   = rej_q;
   assign o_trip_cnt    = trip_q;
   assign o_fsm_state   = fsm_q;

endmodule

// File: tb/tb_mps_intl_handler.sv
// Directed bench for mps_intl_handler: a table of timed input steps with
// hand-derived outputs, plus a reset-during-run sequence.
module tb_mps_intl_handler;

   localparam int N = 16;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  raw;
   logic [N-1:0]  mask;
   logic [15:0]   db;
   logic          req;
   logic          clr;
   logic          pwm_en;
   logic [N-1:0]  live;
   logic [N-1:0]  st;
   logic          any;
   logic [3:0]    fidx;
   logic          fvld;
   logic          rej;
   logic [15:0]   trip;
   logic [1:0]    fsm;

   int n_cmp = 0;
   int n_bad = 0;

   mps_intl_handler #(
      .C_INTL_NUM (N),
      .C_INTL_POL (16'hFFFE),
      .C_DB_WIDTH (16)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst_n),
      .i_intl_raw    (raw),
      .i_intl_mask   (mask),
      .i_db_cnt      (db),
      .i_pwm_en_req  (req),
      .i_clear       (clr),
      .o_pwm_en      (pwm_en),
      .o_intl_live   (live),
      .o_intl_state  (st),
      .o_intl_any    (any),
      .o_first_idx   (fidx),
      .o_first_valid (fvld),
      .o_clear_rej   (rej),
      .o_trip_cnt    (trip),
      .o_fsm_state   (fsm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] raw;
      logic [15:0] mask;
      logic [15:0] db;
      logic        req;
      logic        clr;
      int          cyc;
      logic        pwm;
      logic [15:0] live;
      logic [15:0] st;
      logic [1:0]  fsm;
      logic [3:0]  fidx;
      logic        fvld;
      logic        rej;
      logic [15:0] trip;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [15:0] r, logic [15:0] m, logic [15:0] d, logic q,
                               logic c, int n, logic p, logic [15:0] l, logic [15:0] s,
                               logic [1:0] f, logic [3:0] fi, logic fv, logic rj,
                               logic [15:0] t);
      vec_t v;
      v.raw = r; v.mask = m; v.db = d; v.req = q; v.clr = c; v.cyc = n;
      v.pwm = p; v.live = l; v.st = s; v.fsm = f; v.fidx = fi; v.fvld = fv;
      v.rej = rj; v.trip = t;
      return v;
   endfunction

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic chk_all(int row, logic p, logic [15:0] l, logic [15:0] s, logic [1:0] f,
                          logic [3:0] fi, logic fv, logic rj, logic [15:0] t);
      chk("pwm_en", row, 32'(pwm_en), 32'(p));
      chk("live", row, 32'(live), 32'(l));
      chk("state", row, 32'(st), 32'(s));
      chk("any", row, 32'(any), 32'(|s));
      chk("fsm", row, 32'(fsm), 32'(f));
      chk("first_idx", row, 32'(fidx), 32'(fi));
      chk("first_valid", row, 32'(fvld), 32'(fv));
      chk("clear_rej", row, 32'(rej), 32'(rj));
      chk("trip_cnt", row, 32'(trip), 32'(t));
   endtask

   initial begin
      // raw bit 0 is active-low: idle pin level is 1
      rst_n = 1'b0; raw = 16'h0001; mask = 16'hFFFF; db = 16'd4; req = 1'b0; clr = 1'b0;
      tick(3);
      chk_all(-1, 0, 16'h0, 16'h0, 2'd0, 4'd0, 0, 0, 16'd0);
      rst_n = 1'b1;

      //          raw       mask      db    rq c  cyc pwm live      state     fsm  fi  fv rj trip
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 0, 0, 6,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 0, 1,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 0));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 0, 1,  1, 16'h0000, 16'h0000, 2'd1, 0, 0, 0, 0));
      vecs.push_back(mk(16'h0021, 16'hFFFF, 16'd4, 1, 0, 6,  1, 16'h0000, 16'h0000, 2'd1, 0, 0, 0, 0));
      vecs.push_back(mk(16'h0021, 16'hFFFF, 16'd4, 1, 0, 1,  1, 16'h0020, 16'h0000, 2'd1, 0, 0, 0, 0));
      vecs.push_back(mk(16'h0021, 16'hFFFF, 16'd4, 1, 0, 1,  0, 16'h0020, 16'h0020, 2'd2, 5, 1, 0, 1));
      vecs.push_back(mk(16'h0021, 16'hFFFF, 16'd4, 1, 1, 1,  0, 16'h0020, 16'h0020, 2'd2, 5, 1, 1, 1));
      vecs.push_back(mk(16'h0021, 16'hFFFF, 16'd4, 1, 0, 1,  0, 16'h0020, 16'h0020, 2'd2, 5, 1, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 0, 6,  0, 16'h0020, 16'h0020, 2'd2, 5, 1, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 0, 1,  0, 16'h0000, 16'h0020, 2'd2, 5, 1, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 1, 1,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 0, 4,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 1, 1,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 0, 0, 3,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 0, 2,  1, 16'h0000, 16'h0000, 2'd1, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0081, 16'hFF7F, 16'd4, 1, 0, 7,  1, 16'h0080, 16'h0000, 2'd1, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0081, 16'hFF7F, 16'd4, 1, 0, 5,  1, 16'h0080, 16'h0000, 2'd1, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFF7F, 16'd4, 1, 0, 7,  1, 16'h0000, 16'h0000, 2'd1, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd8, 1, 0, 2,  1, 16'h0000, 16'h0000, 2'd1, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0009, 16'hFFFF, 16'd8, 1, 0, 7,  1, 16'h0000, 16'h0000, 2'd1, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd8, 1, 0, 12, 1, 16'h0000, 16'h0000, 2'd1, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0009, 16'hFFFF, 16'd8, 1, 0, 8,  1, 16'h0000, 16'h0000, 2'd1, 0, 0, 0, 1));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd8, 1, 0, 4,  0, 16'h0008, 16'h0008, 2'd2, 3, 1, 0, 2));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd8, 1, 0, 10, 0, 16'h0000, 16'h0008, 2'd2, 3, 1, 0, 2));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd8, 1, 1, 1,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 2));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 0, 2,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 2));
      vecs.push_back(mk(16'h0205, 16'hFFFF, 16'd4, 1, 0, 8,  0, 16'h0204, 16'h0204, 2'd2, 2, 1, 0, 2));
      vecs.push_back(mk(16'h0204, 16'hFFFF, 16'd4, 1, 0, 8,  0, 16'h0205, 16'h0205, 2'd2, 2, 1, 0, 2));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 0, 8,  0, 16'h0000, 16'h0205, 2'd2, 2, 1, 0, 2));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 1, 1,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 2));
      vecs.push_back(mk(16'h0001, 16'hFFFF, 16'd4, 1, 0, 1,  0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 2));

      for (int i = 0; i < vecs.size(); i++) begin
         raw = vecs[i].raw; mask = vecs[i].mask; db = vecs[i].db;
         req = vecs[i].req; clr = vecs[i].clr;
         tick(vecs[i].cyc);
         chk_all(i, vecs[i].pwm, vecs[i].live, vecs[i].st, vecs[i].fsm,
                 vecs[i].fidx, vecs[i].fvld, vecs[i].rej, vecs[i].trip);
      end

      // Reset while running: enable must drop without waiting for a clock edge
      req = 1'b0; tick(3);
      req = 1'b1; tick(2);
      chk("run_before_reset", 100, 32'(pwm_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_all(101, 0, 16'h0, 16'h0, 2'd0, 4'd0, 0, 0, 16'd0);
      tick(2);
      rst_n = 1'b1;
      tick(6);
      chk_all(102, 0, 16'h0, 16'h0, 2'd0, 4'd0, 0, 0, 16'd0);
      req = 1'b0; tick(3);
      req = 1'b1; tick(2);
      chk_all(103, 1, 16'h0, 16'h0, 2'd1, 4'd0, 0, 0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mps_intl_handler.md
# mps_intl_handler

Parametrised interlock manager for the MPS core, replacing the single "any bit set" reduction of the Zynq interlock inputs. For each of N channels it synchronises and debounces the input, applies a fixed polarity and a runtime mask, and latches the fault. It also captures the first-fault index and drives a registered PWM enable through an arm/run/fault state machine. It sits between the board interlock pins, the AXI4-Lite register bank (mask, debounce, request, clear, status readback) and the PWM enable output.

## Interface
- C_INTL_NUM, 16, number of interlock channels (2..32)
- C_INTL_POL, {C_INTL_NUM{1'b1}}, per-channel fault level: 1 = active high, 0 = active low; also the inverse of each synchroniser reset value
- C_DB_WIDTH, 16, debounce counter width
- C_IDX_WIDTH, $clog2(C_INTL_NUM), first-fault index width

Ports:
- i_clk  in  1  system clock (AXI clock domain)
- i_rst  in  1  reset, asynchronous, active-low
- i_intl_raw  in  C_INTL_NUM  asynchronous interlock pins
- i_intl_mask  in  C_INTL_NUM  1 = channel may latch/trip
- i_db_cnt  in  C_DB_WIDTH  stable cycles required; 0 is treated as 1
- i_pwm_en_req  in  1  PWM run request (level)
- i_clear  in  1  one-cycle clear pulse
- o_pwm_en  out  1  registered PWM enable
- o_intl_live  out  C_INTL_NUM  debounced fault level, unmasked
- o_intl_state  out  C_INTL_NUM  latched faults
- o_intl_any  out  1  |o_intl_state
- o_first_idx  out  C_IDX_WIDTH  index of first latched fault
- o_first_valid  out  1  o_first_idx valid
- o_clear_rej  out  1  one-cycle pulse: clear refused
- o_trip_cnt  out  16  saturating count of RUN->FAULT trips
- o_fsm_state  out  2  00 IDLE, 01 RUN, 10 FAULT

## Operation
- Sync: 2-FF per channel. Each FF resets to ~C_INTL_POL[k], the inactive level. fault_raw[k] = sync2[k] ~^ C_INTL_POL[k].
- Debounce per channel:
  - The counter clears when fault_raw == live.
  - Otherwise it increments, saturating at all-ones.
  - When counter+1 >= max(i_db_cnt,1), live toggles and the counter clears.
  - i_db_cnt changes take effect immediately.
- Latch: state[k] <= state[k] | (live[k] & mask[k]). It clears only on an accepted clear. Masking a latched bit does not clear it.
- new_fault = |(live & mask & ~state).
- First fault: on the edge where state goes from all-zero to nonzero, capture the lowest index among the newly set bits and set o_first_valid. Later faults do not change it.
- FSM, with req_rise = i_pwm_en_req & ~req_d (req_d is the registered i_pwm_en_req):
  - IDLE: if state != 0 or new_fault, go to FAULT. Else if req_rise, go to RUN.
  - RUN: if new_fault or state != 0, go to FAULT and increment o_trip_cnt (saturating at 0xFFFF). Else if !i_pwm_en_req, go to IDLE.
  - FAULT: on i_clear, if (live & mask) == 0 and !new_fault, clear state, o_first_valid and o_first_idx and go to IDLE. Otherwise pulse o_clear_rej and stay in FAULT.
  - i_clear outside FAULT is ignored (no o_clear_rej).
- Re-arm: IDLE after reset or after a clear needs a fresh rising edge on i_pwm_en_req. A request held high never re-enables PWM.
- o_pwm_en <= (next_state == RUN). It is therefore low on the same edge that latches a fault.
- Simultaneous events:
  - Clear and new fault in the same cycle: the fault wins, the clear is rejected, the state stays FAULT.
  - Request deassertion and fault in RUN in the same cycle: go to FAULT and count the trip.
- Reset: all outputs 0, counters 0, live 0, state 0, req_d 0, FSM IDLE. Reset mid-run drops o_pwm_en asynchronously.

## Timing
- The input level is first sampled at edge 0, with D = max(i_db_cnt,1).
- Stable input: o_intl_live rises at edge D+2.
- o_intl_state, o_intl_any, o_first_* and o_pwm_en=0 follow at edge D+3.
- A glitch shorter than D cycles (after sync) never reaches live.
- req_rise in IDLE: o_pwm_en=1 one edge after the edge that registers the request high (2 edges from the first sampled high).
- Clear accepted: state/valid low and FSM in IDLE one edge after i_clear.
- o_clear_rej: one-cycle pulse on the edge after the rejected i_clear.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, i_db_cnt=4, mask=0xFFFF, POL all 1, raw=0:
  - raise req -> o_pwm_en=1 after 2 edges, state RUN.
  - raw[5]=1 held -> live[5] at edge 6, o_pwm_en=0, state bit 5, first_idx=5, trip_cnt=1 at edge 7.
- Glitch filtering, i_db_cnt=8: raw[3] pulses 7 cycles -> live/state stay 0, o_pwm_en stays 1. An 8-cycle pulse -> trip.
- Simultaneous bits 9 and 2 fault in the same cycle, then bit 0 later -> first_idx=2, state=0x0205 after bit 0.
- Clear refusal and re-arm:
  - Clear while raw[5] still active -> o_clear_rej pulse, remains FAULT.
  - Release raw, wait D+2, clear -> IDLE, state 0.
  - Req held high gives no PWM; toggling req low->high gives PWM.
- Mask and polarity:
  - mask[7]=0, raw[7]=1 -> live[7]=1, no latch, PWM stays on.
  - Active-low channel (POL bit 0) with pin high after reset -> no spurious fault.
- Reset asserted mid-RUN -> o_pwm_en=0 immediately, all status 0. Hold req high through reset release -> stays IDLE until a new req rising edge.
